rf_ctrl: RTL and testbench
==========================

// Module: rf_ctrl
// PURPOSE
//   Initiator side of the rf load/store interface. Accepts 32-bit RV64 LD/SD instruction words over a
//   valid/ready handshake, decodes them and drives rf (enable, a, b, w, din, load_store) for a fixed
//   number of cycles. Signals completion with a done pulse. Sits between the instruction source and rf.
// PARAMETERS
//   EXEC_CYCLES  1   cycles enable is held high per instruction (>=1)
//   CNT_W        16  width of the optional op counters
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   instr_valid  in   1   instr carries a new instruction word
//   instr_ready  out  1   controller can accept an instruction (IDLE)
//   instr        in   32  RV64 instruction word
//   enable       out  1   rf enable
//   load_store   out  1   1 = load (LD), 0 = store (SD)
//   a            out  5   rf port a: rs2 (store data register), 0 on load
//   b            out  5   rf port b: rs1 (base register)
//   w            out  5   rf write register: rd on load, 0 on store
//   din          out  64  sign-extended immediate offset
//   done         out  1   1-cycle pulse: instruction completed
//   err          out  1   1-cycle pulse: illegal instruction dropped
//   n_loads      out  CNT_W  completed loads   (RF_CTRL_CNT_EN only)
//   n_stores     out  CNT_W  completed stores  (RF_CTRL_CNT_EN only)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; enable, load_store, a, b, w, din, done, err, counters = 0.
//     Asserting rst_n mid-EXEC drops enable immediately; the instruction is discarded, no done.
//   FSM: IDLE -> DECODE -> EXEC -> DONE -> IDLE; DECODE -> ERR -> IDLE.
//     IDLE: instr_ready=1. Handshake on edge with instr_valid&&instr_ready latches instr -> DECODE.
//       instr_ready=0 in every other state; instr_valid outside IDLE is ignored (source holds it).
//     DECODE (1 cycle): legal iff funct3(instr[14:12])==3'b011 and opcode(instr[6:0]) is
//       7'b0000011 (LD) or 7'b0100011 (SD). Legal -> register outputs, go EXEC; else -> ERR.
//       LD: load_store=1, w=instr[11:7], b=instr[19:15], a=0, din=sext(instr[31:20]).
//       SD: load_store=0, a=instr[24:20], b=instr[19:15], w=0, din=sext({instr[31:25],instr[11:7]}).
//       rd=x0 on LD is issued unchanged (rf owns x0 semantics).
//     EXEC: enable=1 for exactly EXEC_CYCLES cycles; a/b/w/din/load_store stable throughout.
//     DONE: enable=0, done=1 for one cycle -> IDLE.
//     ERR: err=1 for one cycle, enable never asserted, outputs keep previous values -> IDLE.
//   Latency: handshake at edge k -> enable high cycles k+2..k+1+EXEC_CYCLES -> done at k+2+EXEC_CYCLES.
//     Next accept earliest at edge k+3+EXEC_CYCLES (throughput 1 instr per EXEC_CYCLES+3 cycles).
//   Outputs a/b/w/din/load_store hold last issued values after DONE until the next legal decode.
//   Sign extension: 12-bit immediate, bit 11 replicated into din[63:12].
//   All outputs registered; done and err never assert in the same cycle.
// CONFIGURATION
//   RF_CTRL_CNT_EN defined: n_loads/n_stores ports exist; increment by 1 in the DONE cycle of each
//     LD/SD; wrap modulo 2^CNT_W; cleared only by reset; illegal instructions never counted.
//   RF_CTRL_CNT_EN undefined: ports and counter logic absent; all other behaviour identical.
// TESTING
//   ld x2,3(x13) = 0x0036B103 -> load_store=1 w=2 b=13 a=0 din=3, enable 1 cycle, done at k+3.
//   sd x4,2(x6) = 0x00433123 -> load_store=0 a=4 b=6 w=0 din=2, enable 1 cycle, done pulse.
//   ld x3,-8(x21) = 0xFF8AB183 -> din=64'hFFFF_FFFF_FFFF_FFF8, w=3, b=21.
//   add x1,x2,x3 = 0x003100B3 -> err pulse at k+2, enable stays 0, no done, instr_ready back at k+3.
//   EXEC_CYCLES=3, rst_n low during 2nd enable cycle -> enable=0 at once, no done, IDLE after release.
//   RF_CTRL_CNT_EN: 2 LD + 1 SD + 1 illegal back-to-back -> n_loads=2, n_stores=1.

Source files
------------

// File: rtl/rf_ctrl.sv
// rf_ctrl: decodes RV64 LD/SD words and drives the rf load/store port for EXEC_CYCLES cycles.
// Optional op counters (n_loads/n_stores) are built when RF_CTRL_CNT_EN is defined.
module rf_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        enable,
    output logic        load_store,
    output logic [4:0]  a,
    output logic [4:0]  b,
    output logic [4:0]  w,
    output logic [63:0] din,
    output logic        done,
    output logic        err
`ifdef RF_CTRL_CNT_EN
    ,
    output logic [CNT_W-1:0] n_loads,
    output logic [CNT_W-1:0] n_stores
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_DONE,
        S_ERR
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned EW     = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [6:0]  OP_LD  = 7'b0000011;
    localparam logic [6:0]  OP_SD  = 7'b0100011;
    localparam logic [2:0]  F3_DW  = 3'b011;

    state_e         state_q, state_d;
    logic [EW-1:0]  exec_cnt_q, exec_cnt_d;
    logic [31:0]    instr_q, instr_d;
    logic           enable_q, enable_d;
    logic           load_store_q, load_store_d;
    logic [4:0]     a_q, a_d;
    logic [4:0]     b_q, b_d;
    logic [4:0]     w_q, w_d;
    logic [63:0]    din_q, din_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           is_ld, is_sd;

    assign is_ld = (instr_q[14:12] == F3_DW) && (instr_q[6:0] == OP_LD);
    assign is_sd = (instr_q[14:12] == F3_DW) && (instr_q[6:0] == OP_SD);

    // enable/done/err are registered images of the state, so they trail it by one cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d      = state_q;
        exec_cnt_d   = exec_cnt_q;
        instr_d      = instr_q;
        load_store_d = load_store_q;
        a_d          = a_q;
        b_d          = b_q;
        w_d          = w_q;
        din_d        = din_q;
        enable_d     = (state_q == S_EXEC);
        done_d       = (state_q == S_DONE);
        err_d        = (state_q == S_ERR);

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                exec_cnt_d = '0;
                if (is_ld) begin
                    load_store_d = 1'b1;
                    a_d          = 5'd0;
                    b_d          = instr_q[19:15];
                    w_d          = instr_q[11:7];
                    din_d        = {{52{instr_q[31]}}, instr_q[31:20]};
                    state_d      = S_EXEC;
                end else if (is_sd) begin
                    load_store_d = 1'b0;
                    a_d          = instr_q[24:20];
                    b_d          = instr_q[19:15];
                    w_d          = 5'd0;
                    din_d        = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                    state_d      = S_EXEC;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if (exec_cnt_q == EW'(EXEC_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    exec_cnt_d = exec_cnt_q + EW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            exec_cnt_q   <= '0;
            instr_q      <= '0;
            enable_q     <= 1'b0;
            load_store_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            w_q          <= '0;
            din_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            exec_cnt_q   <= exec_cnt_d;
            instr_q      <= instr_d;
            enable_q     <= enable_d;
            load_store_q <= load_store_d;
            a_q          <= a_d;
            b_q          <= b_d;
            w_q          <= w_d;
            din_q        <= din_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign enable      = enable_q;
    assign load_store  = load_store_q;
    assign a           = a_q;
    assign b           = b_q;
    assign w           = w_q;
    assign din         = din_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef RF_CTRL_CNT_EN
    cnt_t n_loads_q, n_loads_d;
    cnt_t n_stores_q, n_stores_d;

    // load_store_q still holds the completed op's type during DONE.
    always_comb begin
        n_loads_d  = n_loads_q;
        n_stores_d = n_stores_q;
        if (state_q == S_DONE) begin
            if (load_store_q) begin
                n_loads_d = n_loads_q + cnt_t'(1);
            end else begin
                n_stores_d = n_stores_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_loads_q  <= '0;
            n_stores_q <= '0;
        end else begin
            n_loads_q  <= n_loads_d;
            n_stores_q <= n_stores_d;
        end
    end

    assign n_loads  = n_loads_q;
    assign n_stores = n_stores_q;
`endif

endmodule

// File: tb/tb_rf_ctrl.sv
// Self-checking bench for rf_ctrl: directed LD/SD/illegal sequence with a scoreboard queue,
// plus an EXEC_CYCLES=3 instance for multi-cycle enable and mid-EXEC reset.
module tb_rf_ctrl;

    typedef struct {
        logic        ls;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  w;
        logic [63:0] din;
        logic        is_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, rst3_n;

    logic        instr_valid, instr_ready, enable, load_store, done, err;
    logic [31:0] instr;
    logic [4:0]  a, b, w;
    logic [63:0] din;

    logic        instr_valid3, instr_ready3, enable3, load_store3, done3, err3;
    logic [31:0] instr3;
    logic [4:0]  a3, b3, w3;
    logic [63:0] din3;

`ifdef RF_CTRL_CNT_EN
    logic [15:0] n_loads, n_stores, n_loads3, n_stores3;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t last_ok;
    int   exp_ld = 0;
    int   exp_st = 0;

    rf_ctrl #(.EXEC_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .enable(enable), .load_store(load_store), .a(a), .b(b), .w(w), .din(din),
        .done(done), .err(err)
`ifdef RF_CTRL_CNT_EN
        , .n_loads(n_loads), .n_stores(n_stores)
`endif
    );

    rf_ctrl #(.EXEC_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .instr_valid(instr_valid3), .instr_ready(instr_ready3), .instr(instr3),
        .enable(enable3), .load_store(load_store3), .a(a3), .b(b3), .w(w3), .din(din3),
        .done(done3), .err(err3)
`ifdef RF_CTRL_CNT_EN
        , .n_loads(n_loads3), .n_stores(n_stores3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ok(input logic ls, input logic [4:0] ea, input logic [4:0] eb,
                           input logic [4:0] ew, input logic [63:0] edin);
        exp_t e;
        e.ls = ls; e.a = ea; e.b = eb; e.w = ew; e.din = edin; e.is_err = 1'b0;
        last_ok = e;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = last_ok;
        e.is_err = 1'b1;
        sb.push_back(e);
    endtask

    // Handshake on the next edge (k), then follow the EXEC_CYCLES=1 instance until done/err.
    task automatic issue(input string tag, input logic [31:0] ins);
        exp_t e;
        int   n, en_cnt, en_first;
        bit   seen;
        chk({tag, "_ready_idle"}, 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instr       = ins;
        step();
        instr_valid = 1'b0;
        instr       = $urandom;
        n = 0; en_cnt = 0; en_first = -1; seen = 1'b0;
        while (!seen && n < 16) begin
            step();
            n++;
            if (n == 1) chk({tag, "_ready_busy"}, 64'(instr_ready), 64'd0);
            if (enable) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
            end
            if (done || err) seen = 1'b1;
        end
        chk({tag, "_completed"}, 64'(seen), 64'd1);
        e = sb.pop_front();
        chk({tag, "_done_err_excl"}, 64'(done & err), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'(e.is_err));
        chk({tag, "_done"}, 64'(done), 64'(!e.is_err));
        if (e.is_err) begin
            chk({tag, "_err_cycle"}, 64'(n), 64'd2);
            chk({tag, "_err_no_enable"}, 64'(en_cnt), 64'd0);
        end else begin
            chk({tag, "_done_cycle"}, 64'(n), 64'd3);
            chk({tag, "_en_first"}, 64'(en_first), 64'd2);
            chk({tag, "_en_cycles"}, 64'(en_cnt), 64'd1);
            if (e.ls) exp_ld++; else exp_st++;
        end
        chk({tag, "_load_store"}, 64'(load_store), 64'(e.ls));
        chk({tag, "_a"}, 64'(a), 64'(e.a));
        chk({tag, "_b"}, 64'(b), 64'(e.b));
        chk({tag, "_w"}, 64'(w), 64'(e.w));
        chk({tag, "_din"}, din, e.din);
        chk({tag, "_ready_back"}, 64'(instr_ready), 64'd1);
`ifdef RF_CTRL_CNT_EN
        chk({tag, "_n_loads"}, 64'(n_loads), 64'(16'(exp_ld)));
        chk({tag, "_n_stores"}, 64'(n_stores), 64'(16'(exp_st)));
`endif
    endtask

    initial begin
        int n, en_cnt;
        bit seen, bad;

        rst_n = 1'b0; rst3_n = 1'b0;
        instr_valid = 1'b0; instr = '0;
        instr_valid3 = 1'b0; instr3 = '0;
        last_ok = '{ls: 1'b0, a: 5'd0, b: 5'd0, w: 5'd0, din: 64'd0, is_err: 1'b0};
        step();
        step();
        rst_n = 1'b1; rst3_n = 1'b1;
        step();

        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_load_store", 64'(load_store), 64'd0);
        chk("rst_abw", {49'd0, a, b, w}, 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
`ifdef RF_CTRL_CNT_EN
        chk("rst_counters", {32'd0, n_loads, n_stores}, 64'd0);
`endif

        // ld, sd, ld, illegal back-to-back
        push_ok(1'b1, 5'd0, 5'd13, 5'd2, 64'd3);
        issue("ld_x2_3_x13", 32'h0036B103);
        push_ok(1'b0, 5'd4, 5'd6, 5'd0, 64'd2);
        issue("sd_x4_2_x6", 32'h00433123);
        push_ok(1'b1, 5'd0, 5'd21, 5'd3, 64'hFFFF_FFFF_FFFF_FFF8);
        issue("ld_x3_m8_x21", 32'hFF8AB183);
        push_err();
        issue("add_illegal", 32'h003100B3);
`ifdef RF_CTRL_CNT_EN
        chk("cnt_after_mix_loads", 64'(n_loads), 64'd2);
        chk("cnt_after_mix_stores", 64'(n_stores), 64'd1);
`endif

        // negative store offset, lw (wrong funct3), ld with rd=x0
        push_ok(1'b0, 5'd31, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("sd_x31_m1_x1", 32'hFFF0BFA3);
        push_err();
        issue("lw_illegal", 32'h0036A103);
        push_ok(1'b1, 5'd0, 5'd0, 5'd0, 64'd0);
        issue("ld_x0_0_x0", 32'h00003003);

        // EXEC_CYCLES=3: full instruction
        instr_valid3 = 1'b1;
        instr3       = 32'h0036B103;
        step();
        instr_valid3 = 1'b0;
        n = 0; en_cnt = 0; seen = 1'b0;
        while (!seen && n < 16) begin
            step();
            n++;
            if (enable3) en_cnt++;
            if (done3) seen = 1'b1;
        end
        chk("ec3_completed", 64'(seen), 64'd1);
        chk("ec3_done_cycle", 64'(n), 64'd5);
        chk("ec3_en_cycles", 64'(en_cnt), 64'd3);
        chk("ec3_outputs", {38'd0, load_store3, a3, b3, w3, 5'd0}, {38'd0, 1'b1, 5'd0, 5'd13, 5'd2, 5'd0});
        chk("ec3_din", din3, 64'd3);
`ifdef RF_CTRL_CNT_EN
        chk("ec3_n_loads", 64'(n_loads3), 64'd1);
`endif

        // EXEC_CYCLES=3: reset during 2nd enable cycle of a store
        instr_valid3 = 1'b1;
        instr3       = 32'h00433123;
        step();
        instr_valid3 = 1'b0;
        step();
        step();
        chk("ec3_rst_en1", 64'(enable3), 64'd1);
        step();
        chk("ec3_rst_en2", 64'(enable3), 64'd1);
        #2 rst3_n = 1'b0;
        #1;
        chk("ec3_rst_enable_drop", 64'(enable3), 64'd0);
        chk("ec3_rst_outputs", {38'd0, load_store3, a3, b3, w3, done3, err3, 3'd0}, 64'd0);
        chk("ec3_rst_din", din3, 64'd0);
        chk("ec3_rst_ready", 64'(instr_ready3), 64'd1);
`ifdef RF_CTRL_CNT_EN
        chk("ec3_rst_counters", {32'd0, n_loads3, n_stores3}, 64'd0);
`endif
        step();
        rst3_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done3 || enable3 || err3) bad = 1'b1;
        end
        chk("ec3_rst_no_done", 64'(bad), 64'd0);
        chk("ec3_rst_idle", 64'(instr_ready3), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
